fip_div_seq: RTL and testbench
==============================

Name: fip_div_seq

Overview:
- Sequential, parametrised signed fixed-point divider computing z = x / y. Format is Q(WIDTH-FRA_BITS).FRA_BITS.
- Generational successor to the fixed 32-bit divider. It adds:
  - selectable width and fraction bits;
  - optional round-to-nearest;
  - divide-by-zero and overflow flags;
  - a busy/valid start handshake with back-to-back issue.
- Used by the vector-normal and intersection pipelines wherever a single shared divider is time-multiplexed.

Parameters:
- WIDTH, 32, operand and result width in bits, two's complement, range 8..64.
- FRA_BITS, 16, number of fraction bits, range 0..WIDTH-1.
- SAT, 1, 1 = saturate on overflow; 0 = wrap (keep low WIDTH bits of the two's-complement result).
- ROUND, 0, 0 = truncate magnitude (toward zero); 1 = round to nearest, ties away from zero.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_en  in  1  start request; accepted only when o_busy=0.
- i_x  in  WIDTH  dividend, signed fixed point.
- i_y  in  WIDTH  divisor, signed fixed point.
- o_z  out  WIDTH  quotient; holds its last value until the next completion.
- o_busy  out  1  high while a division is in flight.
- o_valid  out  1  one-cycle pulse when o_z, o_ovf and o_dbz are updated.
- o_ovf  out  1  result exceeded the representable range; qualified by o_valid.
- o_dbz  out  1  divisor was zero; qualified by o_valid.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rstn is asynchronous, active-low.
- Reset values: o_z=0, o_busy=0, o_valid=0, o_ovf=0, o_dbz=0; FSM in IDLE.
- Reset mid-operation aborts the division. No o_valid is produced for the aborted operation.
- Iteration count: N = WIDTH + FRA_BITS + ROUND.
- FSM states IDLE, DIV, FIN:
  - IDLE: on i_en=1, capture the operands.
    - Store the sign as sign(x) XOR sign(y).
    - Store magnitudes |x| and |y| as WIDTH-bit unsigned values; |MIN| = 2^(WIDTH-1) is exact.
    - Load the dividend as |x| << (FRA_BITS+ROUND), N bits.
    - Set the counter to N-1, set o_busy=1, go to DIV.
  - DIV: radix-2 restoring division, one quotient bit per cycle, MSB first.
    - The partial remainder is WIDTH+1 bits.
    - Go to FIN when the counter reaches 0.
  - FIN:
    - If ROUND=1, add the guard bit (LSB of the raw quotient) to magnitude = raw >> 1.
    - Apply the sign, then run the range check.
    - Register o_z, o_ovf and o_dbz; pulse o_valid=1; drop o_busy to 0; return to IDLE.
- Latency: the accept edge is edge 0. o_valid is high in the cycle after edge N+1, i.e. latency N+1 cycles: 49 for the defaults, 50 with ROUND=1. Latency is fixed for every input, including y=0.
- Back-to-back: o_busy=0 in the o_valid cycle, so i_en in that cycle is accepted.
- i_en while o_busy=1 is ignored; no queuing.
- Range check:
  - Positive result: overflow if magnitude > 2^(WIDTH-1)-1.
  - Negative result: overflow if magnitude > 2^(WIDTH-1).
  - On overflow, o_ovf=1 regardless of SAT. With SAT=1, o_z = MAX or MIN according to sign.
- Divide by zero (y=0):
  - o_dbz=1 and o_ovf=0.
  - o_z = MAX when x>=0, MIN when x<0, independent of SAT.
  - The quotient datapath result is discarded.
- Zero result with negative sign: o_z=0; no negative zero exists.
- i_x and i_y may change freely after the accept edge.

Decomposition:
- Shared package fip_pkg:
  - constants FIP_MIN and FIP_MAX for 32-bit;
  - functions fip_max(width) and fip_min(width);
  - typedef fip_div_state_t {IDLE, DIV, FIN}.
- One sub-module: fip_div_post, combinational. It performs round, sign apply, and saturate/wrap, and generates o_ovf. It is reusable by the future sqrt and normaliser blocks.
- FSM, counter and restoring datapath stay in fip_div_seq.

Test Plan:
1. Defaults, x=0x00020000 (2.0), y=0x00020000, i_en one cycle -> o_z=0x00010000, o_ovf=0, o_dbz=0. o_valid is exactly one cycle, 49 cycles after acceptance; o_busy is high for cycles 0..48.
2. x=2, y=3 with ROUND=0 -> o_z=43690 (0x0000AAAA). Same inputs with ROUND=1 -> o_z=43691, valid at 50 cycles. x=-1.0 (0xFFFF0000), y=0.5 (0x00008000) -> o_z=0xFFFE0000.
3. Overflow cases:
   - SAT=1: x=0x7FFFFFFF, y=0x00004000 -> o_z=0x7FFFFFFF, o_ovf=1.
   - SAT=1: x=0x80000000, y=0x00004000 -> o_z=0x80000000, o_ovf=1.
   - SAT=1: x=0x80000000, y=0xFFFF0000 -> o_z=0x7FFFFFFF, o_ovf=1.
   - SAT=0: x=0x7FFFFFFF, y=0x00004000 -> o_z equals the low 32 bits of the wrapped quotient, o_ovf=1.
4. Divide by zero:
   - x=5.0 (0x00050000), y=0 -> o_z=0x7FFFFFFF, o_dbz=1, o_ovf=0, latency 49.
   - x=-5.0, y=0 -> o_z=0x80000000, o_dbz=1.
5. Handshake:
   - Hold i_en=1 continuously with new operands each cycle -> one result every 50 cycles. Operands presented while busy are dropped; the operands present in each o_valid cycle are accepted.
   - Pull i_rstn low mid-DIV -> all outputs 0 immediately. No o_valid after release; the next operation completes normally.
6. WIDTH=24, FRA_BITS=8: x=0x000300 (3.0), y=0x000200 (2.0) -> o_z=0x000180 (1.5), latency 33 cycles.

Source files
------------

// File: rtl/fip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fip_pkg
// Description : Shared fixed-point helpers. Range constants, range functions
//               and the sequential divider state type.
// Revision    : 1.0 - initial release
// ============================================================================
package fip_pkg;

    // Q16.16 range limits for the legacy 32-bit datapaths
    localparam logic [31:0] FIP_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] FIP_MIN = 32'h8000_0000;

    // Sequential divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } fip_div_state_t;

    // Largest positive two's-complement value of the given width (zero-extended)
    function automatic logic [63:0] fip_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative value of the given width (zero-extended)
    function automatic logic [63:0] fip_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage : fip_pkg
`default_nettype wire

// File: rtl/fip_div_post.sv
`default_nettype none
// ============================================================================
// Module      : fip_div_post
// Description : Combinational post-processing for iterative fixed-point
//               units: optional round, sign apply, saturate/wrap, overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fip_div_post #(
    parameter int WIDTH = 32,
    parameter int QW    = 48,
    parameter int SAT   = 1,
    parameter int ROUND = 0
) (
    input  logic [QW-1:0]    i_raw,
    input  logic             i_neg,
    input  logic             i_dbz,
    input  logic             i_xneg,
    output logic [WIDTH-1:0] o_z,
    output logic             o_ovf
);
    import fip_pkg::*;

    localparam logic [QW-1:0]    c_pos_lim = QW'(fip_max(WIDTH));
    localparam logic [QW-1:0]    c_neg_lim = QW'(fip_min(WIDTH));
    localparam logic [WIDTH-1:0] c_max     = WIDTH'(fip_max(WIDTH));
    localparam logic [WIDTH-1:0] c_min     = WIDTH'(fip_min(WIDTH));

    logic [QW-1:0]    w_mag;
    logic [WIDTH-1:0] w_wrap;
    logic             w_range_ovf;

    // With rounding the raw quotient carries one extra guard bit below the LSB
    generate
        if (ROUND != 0) begin : g_round
            assign w_mag = (i_raw >> 1) + QW'(i_raw[0]);
        end else begin : g_trunc
            assign w_mag = i_raw;
        end
    endgenerate

    // Negating a zero magnitude yields zero, so no negative zero can appear
    assign w_wrap      = i_neg ? -w_mag[WIDTH-1:0] : w_mag[WIDTH-1:0];
    assign w_range_ovf = i_neg ? (w_mag > c_neg_lim) : (w_mag > c_pos_lim);

    // Divide-by-zero overrides everything; otherwise clamp or wrap on overflow
    always_comb begin
        o_z   = w_wrap;
        o_ovf = w_range_ovf;
        if (i_dbz) begin
            o_z   = i_xneg ? c_min : c_max;
            o_ovf = 1'b0;
        end else if (w_range_ovf && (SAT != 0)) begin
            o_z = i_neg ? c_min : c_max;
        end
    end

endmodule : fip_div_post
`default_nettype wire

// File: rtl/fip_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : fip_div_seq
// Description : Sequential signed fixed-point divider z = x / y, radix-2
//               restoring, one quotient bit per clock, fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fip_div_seq #(
    parameter int WIDTH    = 32,
    parameter int FRA_BITS = 16,
    parameter int SAT      = 1,
    parameter int ROUND    = 0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_z,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_ovf,
    output logic             o_dbz
);
    import fip_pkg::*;

    localparam int N    = WIDTH + FRA_BITS + ROUND;
    localparam int SH   = FRA_BITS + ROUND;
    localparam int CNTW = $clog2(N);

    fip_div_state_t   r_state;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [N-1:0]     r_quo;     // dividend bits shift out MSB first, quotient bits shift in
    logic [WIDTH-1:0] r_ymag;
    logic             r_neg;
    logic             r_xneg;
    logic             r_ydz;
    logic [WIDTH-1:0] r_z;
    logic             r_busy;
    logic             r_valid;
    logic             r_ovf;
    logic             r_dbz;

    logic [WIDTH-1:0] w_xmag;
    logic [WIDTH-1:0] w_ymag;
    logic [N-1:0]     w_dvd;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_post_z;
    logic             w_post_ovf;

    // Magnitudes as unsigned WIDTH-bit values; negating MIN gives 2^(WIDTH-1) exactly
    assign w_xmag  = i_x[WIDTH-1] ? -i_x : i_x;
    assign w_ymag  = i_y[WIDTH-1] ? -i_y : i_y;
    assign w_dvd   = N'(w_xmag) << SH;

    assign w_trial = {r_rem[WIDTH-1:0], r_quo[N-1]};
    assign w_ge    = (w_trial >= {1'b0, r_ymag});
    assign w_diff  = w_trial - {1'b0, r_ymag};

    fip_div_post #(
        .WIDTH (WIDTH),
        .QW    (N),
        .SAT   (SAT),
        .ROUND (ROUND)
    ) u_post (
        .i_raw  (r_quo),
        .i_neg  (r_neg),
        .i_dbz  (r_ydz),
        .i_xneg (r_xneg),
        .o_z    (w_post_z),
        .o_ovf  (w_post_ovf)
    );

    // Control FSM, restoring iteration and result registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_ymag  <= '0;
            r_neg   <= 1'b0;
            r_xneg  <= 1'b0;
            r_ydz   <= 1'b0;
            r_z     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_en) begin
                        r_neg   <= i_x[WIDTH-1] ^ i_y[WIDTH-1];
                        r_xneg  <= i_x[WIDTH-1];
                        r_ydz   <= (i_y == '0);
                        r_ymag  <= w_ymag;
                        r_quo   <= w_dvd;
                        r_rem   <= '0;
                        r_cnt   <= CNTW'(N - 1);
                        r_busy  <= 1'b1;
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    r_rem <= w_ge ? w_diff : w_trial;
                    r_quo <= {r_quo[N-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= FIN;
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                FIN: begin
                    r_z     <= w_post_z;
                    r_ovf   <= w_post_ovf;
                    r_dbz   <= r_ydz;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_z     = r_z;
    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_ovf   = r_ovf;
    assign o_dbz   = r_dbz;

endmodule : fip_div_seq
`default_nettype wire

// File: tb/tb_fip_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fip_div_seq
// Description : Scoreboard bench for fip_div_seq. Four configurations share
//               one stimulus bus; each has its own expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fip_div_seq;

    localparam int ND = 4;
    localparam int CW [ND] = '{32, 32, 32, 24};
    localparam int CF [ND] = '{16, 16, 16, 8};
    localparam int CS [ND] = '{1, 1, 0, 1};
    localparam int CR [ND] = '{0, 1, 0, 0};

    localparam int NDIR = 12;
    localparam logic [31:0] DX [NDIR] = '{
        32'h0002_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h7FFF_FFFF,
        32'h8000_0000, 32'h8000_0000, 32'h0005_0000, 32'hFFFB_0000,
        32'h0000_0300, 32'h0000_0000, 32'h0000_0001, 32'h0001_0000};
    localparam logic [31:0] DY [NDIR] = '{
        32'h0002_0000, 32'h0003_0000, 32'h0000_8000, 32'h0000_4000,
        32'h0000_4000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0200, 32'hFFFF_0000, 32'h0003_0000, 32'hFFFD_0000};

    typedef struct {
        logic [63:0] z;
        bit          ovf;
        bit          dbz;
        longint      acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [31:0] xb;
    logic [31:0] yb;
    logic [31:0] z0, z1, z2;
    logic [23:0] z3;
    logic [ND-1:0] busy, valid, ovf, dbz;
    logic [63:0] zz [ND];

    exp_t   sbq [ND][$];
    int     bcnt [ND];
    longint cyc = 0;
    int     total = 0;
    int     bad = 0;

    always #5 clk = ~clk;

    fip_div_seq #(.WIDTH(32), .FRA_BITS(16), .SAT(1), .ROUND(0)) u_d0 (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_x(xb), .i_y(yb),
        .o_z(z0), .o_busy(busy[0]), .o_valid(valid[0]), .o_ovf(ovf[0]), .o_dbz(dbz[0]));
    fip_div_seq #(.WIDTH(32), .FRA_BITS(16), .SAT(1), .ROUND(1)) u_d1 (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_x(xb), .i_y(yb),
        .o_z(z1), .o_busy(busy[1]), .o_valid(valid[1]), .o_ovf(ovf[1]), .o_dbz(dbz[1]));
    fip_div_seq #(.WIDTH(32), .FRA_BITS(16), .SAT(0), .ROUND(0)) u_d2 (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_x(xb), .i_y(yb),
        .o_z(z2), .o_busy(busy[2]), .o_valid(valid[2]), .o_ovf(ovf[2]), .o_dbz(dbz[2]));
    fip_div_seq #(.WIDTH(24), .FRA_BITS(8), .SAT(1), .ROUND(0)) u_d3 (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_x(xb[23:0]), .i_y(yb[23:0]),
        .o_z(z3), .o_busy(busy[3]), .o_valid(valid[3]), .o_ovf(ovf[3]), .o_dbz(dbz[3]));

    assign zz[0] = {32'b0, z0};
    assign zz[1] = {32'b0, z1};
    assign zz[2] = {32'b0, z2};
    assign zz[3] = {40'b0, z3};

    // Reference: exact rational quotient scaled by 2^f, then rounding and range rules
    function automatic void model(input logic [31:0] xr, input logic [31:0] yr,
                                  input int w, input int f, input int s, input int r,
                                  output logic [63:0] z, output bit o_ovf, output bit o_dbz);
        longint mask, xv, yv, ax, ay, mag, maxv, minp, res;
        bit neg;
        mask = (longint'(1) << w) - 1;
        xv   = longint'({32'b0, xr}) & mask;
        yv   = longint'({32'b0, yr}) & mask;
        if (((xv >> (w - 1)) & 1) != 0) xv = xv - (longint'(1) << w);
        if (((yv >> (w - 1)) & 1) != 0) yv = yv - (longint'(1) << w);
        maxv  = (longint'(1) << (w - 1)) - 1;
        minp  = longint'(1) << (w - 1);
        o_dbz = (yv == 0);
        o_ovf = 1'b0;
        if (o_dbz) begin
            z = (xv < 0) ? minp : maxv;
        end else begin
            neg = (xv < 0) != (yv < 0);
            ax  = (xv < 0) ? -xv : xv;
            ay  = (yv < 0) ? -yv : yv;
            if (r != 0) mag = ((ax << (f + 1)) + ay) / (2 * ay);
            else        mag = (ax << f) / ay;
            o_ovf = neg ? (mag > minp) : (mag > maxv);
            res   = neg ? -mag : mag;
            z     = res & mask;
            if (o_ovf && (s != 0)) z = neg ? minp : maxv;
        end
    endfunction

    function automatic void chk(input string name, input int d,
                                input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", name, d, $time, got, want);
        end
    endfunction

    // Stimulus side of the scoreboard: record every operand pair a DUT accepts
    always @(posedge clk) begin
        exp_t e;
        cyc <= cyc + 1;
        for (int d = 0; d < ND; d++) begin
            if (!rstn) begin
                sbq[d].delete();
                bcnt[d] <= 0;
            end else if (en && !busy[d]) begin
                model(xb, yb, CW[d], CF[d], CS[d], CR[d], e.z, e.ovf, e.dbz);
                e.acc = cyc;
                sbq[d].push_back(e);
                bcnt[d] <= CW[d] + CF[d] + CR[d] + 1;
            end else if (bcnt[d] > 0) begin
                bcnt[d] <= bcnt[d] - 1;
            end
        end
    end

    // Monitor: busy against the latency model, results against the queue
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            for (int d = 0; d < ND; d++) begin
                chk("busy", d, {63'b0, busy[d]}, {63'b0, (bcnt[d] > 0)});
                if (valid[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk("unexpected_valid", d, 64'd1, 64'd0);
                    end else begin
                        e = sbq[d].pop_front();
                        chk("z", d, zz[d], e.z);
                        chk("ovf", d, {63'b0, ovf[d]}, {63'b0, e.ovf});
                        chk("dbz", d, {63'b0, dbz[d]}, {63'b0, e.dbz});
                        chk("latency", d, 64'(cyc - e.acc - 1),
                            64'(CW[d] + CF[d] + CR[d] + 1));
                    end
                end
            end
        end
    end

    task automatic check_reset();
        for (int d = 0; d < ND; d++) begin
            chk("rst_z", d, zz[d], 64'd0);
            chk("rst_flags", d, {60'b0, busy[d], valid[d], ovf[d], dbz[d]}, 64'd0);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy != '0) && (k < 300)) begin
            @(negedge clk);
            k++;
        end
        if (busy != '0) chk("idle_timeout", 0, {60'b0, busy}, 64'd0);
    endtask

    task automatic drain();
        int k = 0;
        int pend;
        do begin
            pend = 0;
            for (int d = 0; d < ND; d++) pend += sbq[d].size();
            if (pend != 0) begin
                @(negedge clk);
                k++;
            end
        end while ((pend != 0) && (k < 300));
        if (pend != 0) chk("drain_timeout", 0, 64'(pend), 64'd0);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        wait_idle();
        @(negedge clk);
        en = 1'b1;
        xb = x;
        yb = y;
        @(negedge clk);
        en = 1'b0;
        xb = $urandom;
        yb = $urandom;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 32'h0003_FFFF));
            2: v = 32'($urandom_range(0, 32'h00FF_FFFF));
            3: v = 32'($urandom_range(0, 255));
            default: v = 32'h0;
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        xb   = '0;
        yb   = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset();
        @(negedge clk);
        #2 rstn = 1'b1;

        for (int i = 0; i < NDIR; i++) begin
            issue(DX[i], DY[i]);
            drain();
        end

        for (int i = 0; i < 30; i++) begin
            issue(rnd_op(), rnd_op());
            drain();
        end

        // Continuous start requests with fresh operands every cycle
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            en = 1'b1;
            xb = rnd_op();
            yb = rnd_op();
        end
        @(negedge clk);
        en = 1'b0;
        drain();

        // Abort mid-division, then confirm silence and a clean next operation
        issue(32'h0003_0000, 32'h0002_0000);
        repeat (20) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_reset();
        @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (80) @(negedge clk);
        issue(32'hFFFD_0000, 32'h0002_0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fip_div_seq
`default_nettype wire
